// File: rtl/uart_tx_arbiter.sv
// Round-robin owner arbiter in front of the UART TX serializer: one requester
// holds the byte path for a whole LAST-terminated message.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ_VALID,
    input  logic [8*N_REQ-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]   REQ_LAST,
    output logic [N_REQ-1:0]   REQ_READY,
    output logic               TX_VALID,
    output logic [7:0]         TX_DATA,
    input  logic               TX_READY,
    output logic [N_REQ-1:0]   GRANT,
    output logic               BUSY
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW:0]   N_WIDE   = (PW + 1)'(N_REQ);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_reg, state_next;
    logic [PW-1:0]      ptr_reg, ptr_next;
    logic [PW-1:0]      owner_reg, owner_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [CW-1:0]      cnt_reg, cnt_next;

    logic [2*N_REQ-1:0] dbl_valid;
    logic [N_REQ-1:0]   rot_valid;
    logic [PW:0]        sel_sum;
    logic [PW-1:0]      release_ptr;
    logic               owner_valid;
    logic               timeout_hit;
    logic               own_active;
    logic [7:0]         req_byte [N_REQ];

    // Outputs are gated by RST so no handshake can complete in the reset cycle.
    assign own_active = (state_reg == OWN) && !RST;
    assign TX_VALID   = own_active && REQ_VALID[owner_reg];
    assign TX_DATA    = own_active ? req_byte[owner_reg] : 8'h00;
    assign GRANT      = grant_reg;
    assign BUSY       = (state_reg == OWN);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_byte[gi]  = REQ_DATA[8*gi +: 8];
            assign REQ_READY[gi] = own_active && (owner_reg == PW'(gi)) && TX_READY;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            grant_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            grant_reg <= grant_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        grant_next = grant_reg;
        cnt_next   = cnt_reg;

        // Rotate requests so bit 0 is PTR; the lowest set bit is the winner.
        dbl_valid = {REQ_VALID, REQ_VALID} >> ptr_reg;
        rot_valid = dbl_valid[N_REQ-1:0];
        sel_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_valid[PW'(k)]) begin
                sel_sum = {1'b0, ptr_reg} + (PW + 1)'(k);
            end
        end
        if (sel_sum >= N_WIDE) begin
            sel_sum = sel_sum - N_WIDE;
        end

        release_ptr = (owner_reg == PW'(N_REQ - 1)) ? '0 : owner_reg + PW'(1);
        owner_valid = REQ_VALID[owner_reg];
        timeout_hit = (TIMEOUT > 0) && !owner_valid && (cnt_reg == CNT_LAST);

        case (state_reg)
            IDLE: begin
                if (|REQ_VALID) begin
                    state_next = OWN;
                    owner_next = sel_sum[PW-1:0];
                    grant_next = N_REQ'(1) << sel_sum[PW-1:0];
                    cnt_next   = '0;
                end
            end
            OWN: begin
                if ((owner_valid && TX_READY && REQ_LAST[owner_reg]) || timeout_hit) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = release_ptr;
                    cnt_next   = '0;
                end else if (owner_valid) begin
                    cnt_next = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N_REQ=4, TIMEOUT=8, hand-computed
// cycle-by-cycle expectations for grant, busy and the byte path.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_LAST(req_last),
        .REQ_READY(req_ready), .TX_VALID(tx_valid), .TX_DATA(tx_data),
        .TX_READY(tx_ready), .GRANT(grant), .BUSY(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic r);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        tx_ready  = r;
    endtask

    // Samples at the falling edge, mid-cycle.
    task automatic expect_out(input string tag, input logic [3:0] g, input logic b,
                              input logic tv, input logic [7:0] td, input logic [3:0] rr);
        @(negedge clk);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " tx_valid"}, 32'(tx_valid), 32'(tv));
        if (tv) check({tag, " tx_data"}, 32'(tx_data), 32'(td));
        check({tag, " req_ready"}, 32'(req_ready), 32'(rr));
    endtask

    task automatic step(input string tag, input logic [3:0] g, input logic b,
                        input logic tv, input logic [7:0] td, input logic [3:0] rr);
        expect_out(tag, g, b, tv, td, rr);
        cyc();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        cyc();
        rst = 1'b0;
    endtask

    int       cnt [N];
    logic [3:0] hs;
    int       phase;
    int       own;

    initial begin
        // Reset state, sampled while RST is still asserted
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        cyc();
        step("reset", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        rst = 1'b0;

        // Single requester, three bytes
        do_reset();
        drive(4'b0001, 4'b0000, 32'h0000_0041, 1'b1);
        step("t1 arb", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t1 b0", 4'b0001, 1'b1, 1'b1, 8'h41, 4'b0001);
        drive(4'b0001, 4'b0000, 32'h0000_0042, 1'b1);
        step("t1 b1", 4'b0001, 1'b1, 1'b1, 8'h42, 4'b0001);
        drive(4'b0001, 4'b0001, 32'h0000_0043, 1'b1);
        step("t1 b2", 4'b0001, 1'b1, 1'b1, 8'h43, 4'b0001);
        drive(4'b0011, 4'b0011, 32'h0000_5150, 1'b1);
        step("t1 idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t1 ptr1", 4'b0010, 1'b1, 1'b1, 8'h51, 4'b0010);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        step("t1 end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // Round robin: all four stream 2-byte messages; order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 15; c++) begin
            req_valid = 4'hF;
            tx_ready  = 1'b1;
            for (int i = 0; i < N; i++) begin
                req_data[8*i +: 8] = 8'(16 * i + cnt[i]);
                req_last[i]        = (cnt[i] == 1);
            end
            phase = c % 3;
            own   = (c / 3) % N;
            if (phase == 0)
                expect_out($sformatf("t2 c%0d gap", c), 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
            else
                expect_out($sformatf("t2 c%0d", c), 4'(1 << own), 1'b1, 1'b1,
                           8'(16 * own + phase - 1), 4'(1 << own));
            hs = req_ready & req_valid;
            cyc();
            for (int i = 0; i < N; i++)
                if (hs[i]) cnt[i] = (cnt[i] == 1) ? 0 : cnt[i] + 1;
        end
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        step("t2 end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // No interleave: REQ1 arrives during REQ2's message
        do_reset();
        drive(4'b0100, 4'b0000, 32'h00A0_0000, 1'b1);
        step("t3 arb", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t3 b0", 4'b0100, 1'b1, 1'b1, 8'hA0, 4'b0100);
        drive(4'b0110, 4'b0010, 32'h00A1_B000, 1'b1);
        step("t3 b1", 4'b0100, 1'b1, 1'b1, 8'hA1, 4'b0100);
        drive(4'b0110, 4'b0010, 32'h00A2_B000, 1'b1);
        step("t3 b2", 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0100);
        drive(4'b0110, 4'b0110, 32'h00A3_B000, 1'b1);
        step("t3 b3", 4'b0100, 1'b1, 1'b1, 8'hA3, 4'b0100);
        drive(4'b0010, 4'b0010, 32'h0000_B000, 1'b1);
        step("t3 gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t3 req1", 4'b0010, 1'b1, 1'b1, 8'hB0, 4'b0010);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        step("t3 end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // Backpressure: TX_READY 1,0,0,1
        do_reset();
        drive(4'b0001, 4'b0000, 32'h0000_00C0, 1'b1);
        step("t4 arb", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t4 b0", 4'b0001, 1'b1, 1'b1, 8'hC0, 4'b0001);
        drive(4'b0001, 4'b0001, 32'h0000_00C1, 1'b0);
        step("t4 stall1", 4'b0001, 1'b1, 1'b1, 8'hC1, 4'b0000);
        step("t4 stall2", 4'b0001, 1'b1, 1'b1, 8'hC1, 4'b0000);
        drive(4'b0001, 4'b0001, 32'h0000_00C1, 1'b1);
        step("t4 b1", 4'b0001, 1'b1, 1'b1, 8'hC1, 4'b0001);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        step("t4 end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // Timeout: single-byte message on REQ2 moves PTR to 3, then REQ3 stalls
        do_reset();
        drive(4'b0100, 4'b0100, 32'h00D2_0000, 1'b1);
        step("t5 arb", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t5 single", 4'b0100, 1'b1, 1'b1, 8'hD2, 4'b0100);
        drive(4'b1001, 4'b0001, 32'hD300_00E0, 1'b1);
        step("t5 gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t5 own3", 4'b1000, 1'b1, 1'b1, 8'hD3, 4'b1000);
        drive(4'b0001, 4'b0001, 32'h0000_00E0, 1'b1);
        for (int k = 0; k < 8; k++)
            step($sformatf("t5 idle%0d", k), 4'b1000, 1'b1, 1'b0, 8'h00, 4'b1000);
        step("t5 release", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t5 req0", 4'b0001, 1'b1, 1'b1, 8'hE0, 4'b0001);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        step("t5 end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // Reset mid-message with PTR=1 beforehand
        drive(4'b0100, 4'b0000, 32'h00F0_0000, 1'b1);
        step("t6 arb", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t6 b0", 4'b0100, 1'b1, 1'b1, 8'hF0, 4'b0100);
        drive(4'b0100, 4'b0000, 32'h00F1_0000, 1'b1);
        rst = 1'b1;
        expect_out("t6 rstcyc", 4'b0100, 1'b1, 1'b0, 8'h00, 4'b0000);
        cyc();
        rst = 1'b0;
        drive(4'b0011, 4'b0011, 32'h0000_6160, 1'b1);
        step("t6 after", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step("t6 ptr0", 4'b0001, 1'b1, 1'b1, 8'h60, 4'b0001);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        step("t6 end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single board UART transmitter between several on-chip message sources (button event reporter, switch status reporter, debug printer). Each requester presents a byte stream framed by a LAST flag; the arbiter grants one requester at a time and holds the grant for the whole message so bytes from different sources never interleave on the UART_TX line. It sits between the requesters and the UART TX serializer in the board top level.

## Interface

- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 1024: idle cycles a granted requester may hold the grant with REQ_VALID low before forced release; 0 disables the timeout.

- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high. The top level derives it from the active-low board reset.
- REQ_VALID  input  N_REQ  per-requester byte valid.
- REQ_DATA  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- REQ_LAST  input  N_REQ  per-requester end-of-message flag, qualified by REQ_VALID.
- REQ_READY  output  N_REQ  per-requester byte accepted this cycle when high with REQ_VALID.
- TX_VALID  output  1  byte valid to the UART TX serializer.
- TX_DATA  output  8  byte to the serializer.
- TX_READY  input  1  serializer accepts the byte.
- GRANT  output  N_REQ  one-hot current owner; all zero when idle.
- BUSY  output  1  a message is in progress.

## Operation

- States: IDLE and OWN.
- IDLE:
  - TX_VALID=0, REQ_READY=0, GRANT=0, BUSY=0.
  - If any REQ_VALID bit is set, select the first set bit searching from pointer PTR upward with wrap (PTR, PTR+1, ..., N_REQ-1, 0, ...).
  - Register the selection into GRANT and go to OWN.
- OWN, owner g:
  - TX_VALID=REQ_VALID[g], TX_DATA=REQ_DATA[g], REQ_READY[g]=TX_READY, other REQ_READY bits 0. These paths are combinational.
  - BUSY=1.
  - On handshake (REQ_VALID[g] && TX_READY) with REQ_LAST[g]=1: go to IDLE and set PTR=(g+1) mod N_REQ.
- Timeout:
  - In OWN, an idle counter increments on each cycle with REQ_VALID[g]=0 and clears on each cycle with REQ_VALID[g]=1.
  - When the counter reaches TIMEOUT (TIMEOUT>0), release to IDLE and set PTR=(g+1) mod N_REQ. The partial message is abandoned.
  - The counter clears on every entry to OWN.
- Requests arriving while in OWN are ignored until the return to IDLE. A requester must hold REQ_VALID until served.
- The arbiter never modifies, drops or duplicates bytes.

## Timing

- Reset values: state=IDLE, PTR=0, GRANT=0, BUSY=0, TX_VALID=0, REQ_READY=0, idle counter=0.
- Arbitration latency:
  - REQ_VALID rises in IDLE at cycle t; GRANT and BUSY are high from cycle t+1.
  - The first byte can be accepted at t+1.
- Gap between messages: after the LAST handshake at cycle t, the state is IDLE at t+1 (TX_VALID=0), and the next grant is visible at t+2. The minimum inter-message gap is one cycle.
- Single-byte message (LAST on the first byte): grant and release each take one cycle.
- Simultaneous requests: resolved purely by PTR order; the fixed index is never a tiebreaker beyond that order.
- Timeout release occurs on the cycle after the counter reaches TIMEOUT. GRANT is zero that cycle.
- RST asserted mid-message: next cycle is IDLE with all reset values. The downstream sees TX_VALID drop, and no handshake occurs in the reset cycle.
- TX_READY low stalls indefinitely without affecting the idle counter, since the counter only counts REQ_VALID=0.

## Test plan

- Single requester:
  - Stimulus: REQ 0 sends 3 bytes 0x41,0x42,0x43 (LAST on 0x43) with TX_READY=1.
  - Required response: GRANT=0001 from the cycle after valid; TX_DATA carries 0x41,0x42,0x43 on consecutive cycles; IDLE and PTR=1 afterwards.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously send 2-byte messages from reset.
  - Required response: grant order 0,1,2,3,0; each message is contiguous; exactly one idle cycle between messages.
- No interleave:
  - Stimulus: REQ 2 starts a 4-byte message and REQ 1 raises valid after byte 1.
  - Required response: all 4 bytes of REQ 2 go out first; REQ 1 is granted next (PTR=3 wraps to 0, and REQ 1 is the first set bit).
- Backpressure:
  - Stimulus: TX_READY toggles 1,0,0,1 during a 2-byte message.
  - Required response: bytes are held stable while stalled; REQ_READY mirrors TX_READY; no loss or duplication.
- Timeout:
  - Stimulus: TIMEOUT=8; REQ 3 sends one byte without LAST, then drops valid.
  - Required response: release to IDLE after 8 idle cycles; REQ 0's pending request is granted next.
- Reset mid-message:
  - Stimulus: RST pulse for 1 cycle during byte 2 of a message.
  - Required response: the next cycle shows GRANT=0, BUSY=0, TX_VALID=0, PTR=0.
